// File: rtl/mac_sched_pkg.sv
// Shared types, default sizing and round-robin pick for the MAC dot-product scheduler.
package mac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_LEN_W = 5;
  localparam int DEF_ACC_W = 13;
  localparam int DEF_ID_W  = 2;

  // First set bit of req found scanning upward from last_ptr+1, wrapping at nreq.
  function automatic logic [2:0] rr_pick(input logic [7:0]  req,
                                         input logic [2:0]  last_ptr,
                                         input int unsigned nreq);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= nreq; k++) begin
      idx = (32'(last_ptr) + k) % nreq;
      if (!found && req[3'(idx)]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Two-stage 4x4 multiply / accumulate: product register, then accumulator.
module mac_pipe
  import mac_sched_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic [ACC_W-1:0] acc
);

  logic [7:0]       prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Next product and accumulator values; clear wins over a pending product.
  always_comb begin
    prod_d   = 8'(a) * 8'(b);
    prod_v_d = en;
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (prod_v_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_dot_scheduler.sv
// Round-robin scheduler sharing one MAC pipeline among NREQ dot-product requesters.
module mac_dot_scheduler
  import mac_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int LEN_W = DEF_LEN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*4-1:0]     in1_bus,
  input  logic [NREQ*4-1:0]     in2_bus,
  output logic [NREQ-1:0]       in_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   winner_q, winner_d;
  logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;

  logic [7:0]        req_ext;
  logic [ID_W-1:0]   pick;
  logic [LEN_W-1:0]  pick_len;
  logic              sel_valid;
  logic [3:0]        sel_a, sel_b;
  logic              accept;
  logic              clr;
  logic [ACC_W-1:0]  acc;

  // Arbitration candidate and its job length, evaluated every cycle.
  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    pick                = ID_W'(rr_pick(req_ext, 3'(last_ptr_q), NREQ));
    pick_len            = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == ID_W'(i)) pick_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Operand and valid mux from the granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner_q == ID_W'(i)) begin
        sel_valid = in_valid[i];
        sel_a     = in1_bus[i*4 +: 4];
        sel_b     = in2_bus[i*4 +: 4];
      end
    end
    accept = (state_q == ST_STREAM) && sel_valid;
  end

  // State register and job bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      winner_q   <= '0;
      last_ptr_q <= ID_W'(NREQ - 1);
      len_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_ptr_q <= last_ptr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, count accepts, hand off result.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_ptr_d = last_ptr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    clr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          winner_d       = pick;
          len_d          = pick_len;
          cnt_d          = '0;
          grant_d        = '0;
          grant_d[pick]  = 1'b1;
          clr            = 1'b1;
          state_d        = (pick_len == '0) ? ST_OUT : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          last_ptr_d = winner_q;
          grant_d    = '0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    grant     = grant_q;
    in_ready  = (state_q == ST_STREAM) ? grant_q : '0;
    res_valid = (state_q == ST_OUT);
    res       = (state_q == ST_OUT) ? acc : '0;
    res_id    = (state_q == ST_OUT) ? winner_q : '0;
    busy      = (state_q != ST_IDLE);
  end

  mac_pipe #(
    .ACC_W (ACC_W)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (accept),
    .a     (sel_a),
    .b     (sel_b),
    .acc   (acc)
  );

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Directed and randomized checks of mac_dot_scheduler against a sum-of-products model.
module tb_mac_dot_scheduler;

  localparam int NREQ  = 4;
  localparam int LEN_W = 5;
  localparam int ACC_W = 13;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       in_valid;
  logic [NREQ*4-1:0]     in1_bus;
  logic [NREQ*4-1:0]     in2_bus;
  logic [NREQ-1:0]       in_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_W-1:0]      res;
  logic [ID_W-1:0]       res_id;
  logic                  busy;

  int         vectors     = 0;
  int         miscompares = 0;
  int         exp_last;
  int         job_len [NREQ];
  logic [3:0] op_a [32];
  logic [3:0] op_b [32];
  logic [3:0] ra [NREQ];
  logic [3:0] rb [NREQ];

  always #5 clk = ~clk;

  mac_dot_scheduler #(
    .NREQ  (NREQ),
    .LEN_W (LEN_W),
    .ACC_W (ACC_W),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .in_valid  (in_valid),
    .in1_bus   (in1_bus),
    .in2_bus   (in2_bus),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next owner: first requester after the previous owner, cyclically.
  function automatic int rr_model(input logic [NREQ-1:0] m, input int last);
    for (int s = 1; s <= NREQ; s++) begin
      if (m[(last + s) % NREQ]) return (last + s) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_lens();
    for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'(job_len[i]);
  endtask

  task automatic rand_bus();
    in_valid = 4'($urandom);
    in1_bus  = 16'($urandom);
    in2_bus  = 16'($urandom);
  endtask

  // mode: 0 = no bubbles, 1 = valid every other cycle, 2 = random bubbles.
  task automatic run_job(input logic [NREQ-1:0] mask, input int mode, input int wait_c,
                         input int abort_at, input logic [NREQ-1:0] pend);
    int w, len, k, guard, exp_sum;
    logic v;
    logic [NREQ-1:0] g1h;
    w   = rr_model(mask, exp_last);
    len = job_len[w];
    g1h = 4'(1 << w);
    set_lens();
    req = mask;
    rand_bus();
    @(negedge clk);
    chk("grant_arb", 32'(grant), 32'(g1h));
    chk("in_ready_arb", 32'(in_ready), (len > 0) ? 32'(g1h) : 32'd0);
    chk("busy_arb", 32'(busy), 32'd1);
    req = pend;
    exp_sum = 0;
    k = 0;
    guard = 0;
    if (len > 0) begin
      while (k < len) begin
        chk("in_ready_stream", 32'(in_ready), 32'(g1h));
        chk("res_valid_stream", 32'(res_valid), 32'd0);
        if (mode == 0)      v = 1'b1;
        else if (mode == 1) v = (guard % 2 == 0);
        else                v = ($urandom_range(99) >= 30) || (guard > 100);
        rand_bus();
        in_valid[w] = v;
        in1_bus[w*4 +: 4] = op_a[k];
        in2_bus[w*4 +: 4] = op_b[k];
        if (v) begin
          exp_sum += int'(op_a[k]) * int'(op_b[k]);
          k++;
        end
        guard++;
        @(negedge clk);
        if (k == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_grant", 32'(grant), 32'd0);
          chk("rst_in_ready", 32'(in_ready), 32'd0);
          chk("rst_res_valid", 32'(res_valid), 32'd0);
          chk("rst_res", 32'(res), 32'd0);
          chk("rst_res_id", 32'(res_id), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          req = '0;
          in_valid = '0;
          @(negedge clk);
          rst_n = 1'b1;
          exp_last = NREQ - 1;
          return;
        end
      end
      rand_bus();
      chk("in_ready_drain", 32'(in_ready), 32'd0);
      chk("res_valid_drain", 32'(res_valid), 32'd0);
      chk("grant_drain", 32'(grant), 32'(g1h));
      @(negedge clk);
    end
    chk("res_valid_out", 32'(res_valid), 32'd1);
    chk("res_out", 32'(res), 32'(exp_sum));
    chk("res_id_out", 32'(res_id), 32'(w));
    for (int i = 0; i < wait_c; i++) begin
      res_ready = 1'b0;
      rand_bus();
      @(negedge clk);
      chk("res_valid_hold", 32'(res_valid), 32'd1);
      chk("res_hold", 32'(res), 32'(exp_sum));
      chk("res_id_hold", 32'(res_id), 32'(w));
      chk("grant_hold", 32'(grant), 32'(g1h));
      chk("in_ready_hold", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_done", 32'(res_valid), 32'd0);
    chk("grant_done", 32'(grant), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    exp_last = w;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, njobs;
    logic [NREQ-1:0] prev_g;
    logic prev_rv;
    rst_n     = 1'b1;
    req       = '0;
    req_len   = '0;
    in_valid  = '0;
    in1_bus   = '0;
    in2_bus   = '0;
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) job_len[i] = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_res_id", 32'(res_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    exp_last = NREQ - 1;
    @(negedge clk);

    // Three pairs, no bubbles.
    job_len[0] = 3;
    op_a[0] = 4'd3;  op_b[0] = 4'd4;
    op_a[1] = 4'd15; op_b[1] = 4'd15;
    op_a[2] = 4'd0;  op_b[2] = 4'd9;
    run_job(4'b0001, 0, 0, -1, 4'b0000);

    // Longest job of maximum operands, valid toggling.
    job_len[1] = 31;
    for (int p = 0; p < 32; p++) begin op_a[p] = 4'd15; op_b[p] = 4'd15; end
    run_job(4'b0010, 1, 1, -1, 4'b0000);

    // Zero-length job.
    job_len[3] = 0;
    run_job(4'b1000, 0, 2, -1, 4'b0000);

    // Two requesters held high, one-pair jobs, result always accepted.
    job_len[0] = 1;
    job_len[2] = 1;
    set_lens();
    for (int i = 0; i < NREQ; i++) begin ra[i] = 4'($urandom); rb[i] = 4'($urandom); end
    for (int i = 0; i < NREQ; i++) begin in1_bus[i*4 +: 4] = ra[i]; in2_bus[i*4 +: 4] = rb[i]; end
    in_valid  = '1;
    res_ready = 1'b1;
    req       = 4'b0101;
    prev_g    = '0;
    prev_rv   = 1'b0;
    njobs     = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("rr_onehot", 32'($onehot0(grant)), 32'd1);
      if (prev_rv) chk("rr_idle_gap", 32'(grant), 32'd0);
      if (grant != '0 && prev_g == '0) begin
        w = rr_model(req, exp_last);
        chk("rr_grant", 32'(grant), 32'(1 << w));
        exp_last = w;
        njobs++;
      end else if (grant != '0) begin
        chk("rr_grant_stable", 32'(grant), 32'(prev_g));
      end
      if (res_valid) begin
        chk("rr_res", 32'(res), 32'(int'(ra[exp_last]) * int'(rb[exp_last])));
        chk("rr_res_id", 32'(res_id), 32'(exp_last));
      end
      prev_g  = grant;
      prev_rv = res_valid;
    end
    req       = '0;
    in_valid  = '0;
    res_ready = 1'b0;
    chk("rr_jobs", 32'(njobs), 32'd4);
    @(negedge clk);
    chk("rr_quiet", 32'(grant), 32'd0);

    // Result held back while another requester waits.
    job_len[0] = 2;
    job_len[1] = 3;
    for (int p = 0; p < 32; p++) begin op_a[p] = 4'($urandom); op_b[p] = 4'($urandom); end
    run_job(4'b0001, 0, 5, -1, 4'b0010);
    run_job(4'b0010, 0, 0, -1, 4'b0000);

    // Reset mid-job, then a fresh job.
    job_len[2] = 4;
    run_job(4'b0100, 0, 0, 2, 4'b0000);
    job_len[1] = 2;
    op_a[0] = 4'd2; op_b[0] = 4'd3;
    op_a[1] = 4'd4; op_b[1] = 4'd5;
    run_job(4'b0010, 0, 0, -1, 4'b0000);

    // Randomized jobs with random request masks.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NREQ; i++) job_len[i] = $urandom_range(0, 31);
      for (int p = 0; p < 32; p++) begin op_a[p] = 4'($urandom); op_b[p] = 4'($urandom); end
      run_job(4'($urandom_range(1, 15)), 2 * $urandom_range(0, 1), $urandom_range(0, 3), -1,
              4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
